// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the nibble-serial adder and its 4-bit datapath.
//   NIBBLE_W    : width of one adder pass (bits)
//   add_state_e : control states of the serial adder
//   nibble_count: number of adder passes needed for a given operand width
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } add_state_e;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// Purely combinational 4-bit ripple-carry adder built from full-adder cells.
//   A, B : 4-bit addends
//   Cin  : carry into bit 0
//   Sum  : 4-bit sum
//   Cout : carry out of bit 3
// ---------------------------------------------------------------------------
module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] carry;

  assign carry[0] = Cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign Sum[gi]       = A[gi] ^ B[gi] ^ carry[gi];
    assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
  end

  assign Cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Adds two WIDTH-bit operands plus a carry-in by passing one nibble per clock
// through a single 4-bit ripple-carry adder. Operands arrive on a valid/ready
// handshake; the registered result leaves on a second valid/ready handshake.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : op_a/op_b/cin valid          in_ready : can accept operands
//   op_a,op_b : WIDTH-bit operands           cin      : carry into bit 0
//   out_valid : sum/cout valid               out_ready: consumer accepts
//   sum       : WIDTH-bit result             cout     : carry out of MSB
//   busy      : an operation is in ADD or DONE
// ---------------------------------------------------------------------------
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = nibble_count(WIDTH);
  localparam int CNT_W   = $clog2(NIBBLES);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  add_state_e       state_reg, state_next;
  logic [WIDTH-1:0] shift_a_reg, shift_a_next;
  logic [WIDTH-1:0] shift_b_reg, shift_b_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             out_valid_reg, out_valid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

  // The low nibble of each operand shift register is always the pair being
  // added this cycle; carry_reg links consecutive passes.
  ripple_carry_adder u_rca (
    .A    (shift_a_reg[NIBBLE_W-1:0]),
    .B    (shift_b_reg[NIBBLE_W-1:0]),
    .Cin  (carry_reg),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_a_reg   <= '0;
      shift_b_reg   <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      shift_a_reg   <= shift_a_next;
      shift_b_reg   <= shift_b_next;
      result_reg    <= result_next;
      carry_reg     <= carry_next;
      cout_reg      <= cout_next;
      out_valid_reg <= out_valid_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_a_next   = shift_a_reg;
    shift_b_next   = shift_b_reg;
    result_next    = result_reg;
    carry_next     = carry_reg;
    cout_next      = cout_reg;
    out_valid_next = out_valid_reg;
    cnt_next       = cnt_reg;
    in_ready       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_a_next = op_a;
          shift_b_next = op_b;
          carry_next   = cin;
          cnt_next     = '0;
          state_next   = ADD;
        end
      end

      ADD: begin
        shift_a_next = shift_a_reg >> NIBBLE_W;
        shift_b_next = shift_b_reg >> NIBBLE_W;
        // New nibbles enter at the top; after NIBBLES passes the first one
        // has arrived at bit 0 and the result is in natural order.
        result_next  = {add_sum, result_reg[WIDTH-1:NIBBLE_W]};
        carry_next   = add_cout;
        if (cnt_reg == CNT_W'(NIBBLES - 1)) begin
          cout_next      = add_cout;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_reg;
  assign sum       = result_reg;
  assign cout      = cout_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Sequential wide-operand adder that reuses the existing 4-bit ripple_carry_adder one nibble per clock. It accepts WIDTH-bit operands over a valid/ready handshake and sends each low nibble pair plus a registered carry into the 4-bit adder. It collects Sum/Cout back into a result register and presents the registered result on an output valid/ready handshake. It sits directly around the 4-bit adder: it feeds the adder and consumes what the adder produces.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 8 (elaboration-time assertion)
NIBBLES, WIDTH/4, derived local parameter; number of adder passes per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operands/cin valid
in_ready  output  1  block can accept operands
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  registered carry out of bit WIDTH-1
busy  output  1  high in ADD or DONE

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state updates on rising clk.
- Reset (rst_n=0 at a clk edge): state=IDLE, sum=0, cout=0, out_valid=0, carry reg=0, nibble counter=0, operand shift regs=0.
- After reset: in_ready=1, busy=0.
- Reset wins over every other event, including mid-ADD and a pending DONE; the in-flight operation is discarded with no output.
- Three FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: capture op_a and op_b into shift regs, set carry reg=cin and counter=0, go to ADD.
- ADD:
  - in_ready=0; in_valid is ignored (no capture, no error).
  - Adder inputs: A=shift_a[3:0], B=shift_b[3:0], Cin=carry reg.
  - Each edge: shift_a and shift_b shift right by 4; the adder Sum nibble enters result[WIDTH-1:WIDTH-4] while result shifts right by 4; carry reg <= adder Cout; counter++.
  - When counter==NIBBLES-1 at an edge: also latch cout <= adder Cout, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1. sum and cout stay stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE. sum and cout keep their last values (don't-care while out_valid=0).
  - in_ready=0 in DONE, so no overlap of accept and drain.
- Latency: out_valid rises exactly NIBBLES edges after the accepting edge (4 for WIDTH=16).
- Minimum issue interval: NIBBLES+2 cycles.
- Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Counter width: $clog2(NIBBLES). The counter does not wrap beyond NIBBLES-1 within one operation.
- in_valid=1 with out_ready=1 held continuously: back-to-back operations, each result delivered once, in order.

Decomposition:
- Shared package adder_pkg:
  - NIBBLE_W=4 constant.
  - add_state_e typedef enum {IDLE, ADD, DONE} with explicit 2-bit encoding.
- One sub-module: ripple_carry_adder (existing, unmodified), instantiated once, combinational, between the shift regs and the result/carry regs.
- No other hierarchy.

Test Plan:
- WIDTH=16, op_a=0x1234, op_b=0x0FED, cin=0 -> out_valid 4 cycles after accept; sum=0x2221, cout=0.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1. Repeat with op_a=0xFFFF, op_b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles across cycles).
- Result 0x8000+0x8000 (sum=0x0000, cout=1) held with out_ready=0 for 6 cycles -> out_valid, sum and cout stable throughout; in_ready=0; one handshake on the out_ready=1 cycle, then back to IDLE.
- in_valid pulsed with op_a=0xAAAA during ADD of 0x0001+0x0001 -> ignored; result 0x0002, cout=0; the next accepted operand is only taken in IDLE.
- rst_n=0 for one edge at the 2nd ADD cycle -> next cycle state=IDLE, out_valid=0, sum=0, cout=0, in_ready=1; no result emitted. A fresh 0x00FF+0x0001 then gives 0x0100.
- in_valid and out_ready held at 1, with 3 queued operand pairs -> 3 results in order, each NIBBLES+2 cycles apart; values match a reference model.
